// File: rtl/spi_slave_sync.sv
// SPI mode-0 slave running in the clk domain: oversampled pins, one BITS-wide frame per ss window.
// Optional SPI_SLAVE_OVERRUN_EN adds i_rx_ack/o_overrun and makes o_rx_valid a level.
module spi_slave_sync #(
  parameter int BITS = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] i_tx_data,
  output logic            o_tx_ready,
  output logic [BITS-1:0] o_rx_data,
  output logic            o_rx_valid,
  output logic            o_busy,
  input  logic            i_sclk,
  input  logic            i_ss,
  input  logic            i_mosi,
  output logic            o_miso
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  input  logic            i_rx_ack,
  output logic            o_overrun
`endif
);

  localparam int CNT_W = $clog2(BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_next;

  logic sclk_s1, sclk_s2, sclk_d;
  logic ss_s1, ss_s2, ss_d;
  logic mosi_s1, mosi_s2;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic frame_done;

  logic [BITS-1:0]  tx_sr;
  logic [BITS-1:0]  rx_sr;
  logic [BITS-1:0]  rx_next;
  logic [CNT_W-1:0] cnt;

  // Synchronizers free-run through reset so a held-low ss is not mistaken for a new fall.
  always_ff @(posedge clk) begin
    sclk_s1 <= i_sclk;
    sclk_s2 <= sclk_s1;
    sclk_d  <= sclk_s2;
    ss_s1   <= i_ss;
    ss_s2   <= ss_s1;
    ss_d    <= ss_s2;
    mosi_s1 <= i_mosi;
    mosi_s2 <= mosi_s1;
  end

  assign sclk_rise  = sclk_s2 & ~sclk_d;
  assign sclk_fall  = ~sclk_s2 & sclk_d;
  assign ss_fall    = ~ss_s2 & ss_d;
  assign ss_rise    = ss_s2 & ~ss_d;
  assign rx_next    = {rx_sr[BITS-2:0], mosi_s2};
  assign frame_done = (state == SHIFT) && !ss_rise && sclk_rise && (cnt == CNT_W'(BITS - 1));

  assign o_busy     = (state != IDLE);
  assign o_tx_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (ss_fall) state_next = SHIFT;
      SHIFT: begin
        if (ss_rise)         state_next = IDLE;
        else if (frame_done) state_next = DONE;
      end
      DONE:  if (ss_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ss rise takes priority over any sclk edge detected in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr  <= '0;
      rx_sr  <= '0;
      cnt    <= '0;
      o_miso <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ss_fall) begin
            tx_sr  <= i_tx_data;
            o_miso <= i_tx_data[BITS-1];
            rx_sr  <= '0;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            o_miso <= 1'b0;
          end else if (sclk_rise) begin
            rx_sr <= rx_next;
            cnt   <= cnt + CNT_W'(1);
          end else if (sclk_fall) begin
            tx_sr  <= tx_sr << 1;
            o_miso <= tx_sr[BITS-2];
          end
        end
        DONE: begin
          if (ss_rise) o_miso <= 1'b0;
        end
        default: o_miso <= 1'b0;
      endcase
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  // A completion wins over a same-cycle ack so the new word stays flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
      o_overrun  <= 1'b0;
    end else if (frame_done) begin
      o_rx_data  <= rx_next;
      o_rx_valid <= 1'b1;
      if (o_rx_valid && !i_rx_ack) o_overrun <= 1'b1;
    end else if (i_rx_ack) begin
      o_rx_valid <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
    end else begin
      o_rx_valid <= frame_done;
      if (frame_done) o_rx_data <= rx_next;
    end
  end
`endif

endmodule
